branch_predictor: RTL and testbench

Dynamic branch predictor for the fetch stage: a direct-mapped table of 2-bit saturating counters with per-entry tag and target. The fetch stage looks it up each cycle with the current PC and gets taken/target. The execute stage writes back the resolved outcome of each conditional branch, the `branch_res` result of branch resolution, so later fetches of the same PC predict it. It also keeps saturating statistics counters for branches resolved and mispredictions.

---
 rtl/branch_predictor.sv | 116 +++++++++++
 tb/tb_branch_predictor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped table of 2-bit saturating counters with
// per-entry tag and target, plus saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_mispredict,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

    localparam int unsigned TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Prediction table
    logic                  r_valid  [ENTRIES];
    logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
    logic [DATA_WIDTH-1:0] r_target [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];

    logic [CNT_WIDTH-1:0]  r_branch_cnt;
    logic [CNT_WIDTH-1:0]  r_mispredict_cnt;

    logic [INDEX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0]   w_if_tag;
    logic                  w_if_hit;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    logic                  w_upd_hit;
    logic [1:0]            w_ctr_next;
    logic                  w_target_wr;
    logic [3:0]            w_unused_pc_lsbs;

    // Word-aligned PCs: the two low bits carry no information.
    assign w_unused_pc_lsbs = {if_pc[1:0], upd_pc[1:0]};

    assign w_if_idx  = if_pc[INDEX_BITS+1:2];
    assign w_if_tag  = if_pc[DATA_WIDTH-1:INDEX_BITS+2];
    assign w_upd_idx = upd_pc[INDEX_BITS+1:2];
    assign w_upd_tag = upd_pc[DATA_WIDTH-1:INDEX_BITS+2];

    // Combinational lookup; reads pre-update state (no bypass).
    always_comb begin
        w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
        pred_hit    = w_if_hit;
        pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
        pred_target = w_if_hit ? r_target[w_if_idx] : '0;
    end

    // Next counter value and target write enable for the resolved branch.
    always_comb begin
        w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
        w_ctr_next  = r_ctr[w_upd_idx];
        w_target_wr = 1'b1;
        if (w_upd_hit) begin
            if (upd_taken) begin
                w_ctr_next = (r_ctr[w_upd_idx] == 2'b11) ? 2'b11 : r_ctr[w_upd_idx] + 2'b01;
            end else begin
                w_ctr_next  = (r_ctr[w_upd_idx] == 2'b00) ? 2'b00 : r_ctr[w_upd_idx] - 2'b01;
                w_target_wr = 1'b0;
            end
        end else begin
            // Fresh allocation starts in the weak state of the observed direction.
            w_ctr_next = upd_taken ? 2'b10 : 2'b01;
        end
    end

    // Table state: reset clears valid and sets weak-not-taken, else apply update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_tag[w_upd_idx]   <= w_upd_tag;
            r_ctr[w_upd_idx]   <= w_ctr_next;
            if (w_target_wr) begin
                r_target[w_upd_idx] <= upd_target;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (upd_valid) begin
            if (r_branch_cnt != CNT_MAX) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (upd_mispredict && (r_mispredict_cnt != CNT_MAX)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
            end
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (CNT_WIDTH=4 to reach saturation).
module tb_branch_predictor;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] if_pc;
    logic          pred_hit;
    logic          pred_taken;
    logic [DW-1:0] pred_target;
    logic          upd_valid;
    logic [DW-1:0] upd_pc;
    logic          upd_taken;
    logic [DW-1:0] upd_target;
    logic          upd_mispredict;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor #(
        .ENTRIES   (16),
        .INDEX_BITS(4),
        .CNT_WIDTH (CW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .pred_hit      (pred_hit),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_mispredict(upd_mispredict),
        .branch_cnt    (branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Look up pc and check hit/taken/target.
    task automatic look(input string tag, input logic [DW-1:0] pc, input logic hit,
                        input logic tk, input logic [DW-1:0] tgt);
        if_pc = pc;
        #1;
        check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        check({tag, "_target"}, pred_target, tgt);
    endtask

    // Apply one update through a clock edge.
    task automatic upd(input logic [DW-1:0] pc, input logic tk, input logic [DW-1:0] tgt,
                       input logic misp);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = misp;
        @(posedge clk);
        #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        if_pc          = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_mispredict = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state over all indices
        for (int i = 0; i < 16; i++) begin
            look("reset_sweep", DW'(i * 4), 1'b0, 1'b0, 32'h0);
        end
        check("reset_branch_cnt", DW'(branch_cnt), 32'd0);
        check("reset_mispredict_cnt", DW'(mispredict_cnt), 32'd0);

        // Allocate and train
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        look("alloc_taken", 32'h100, 1'b1, 1'b1, 32'h80);
        check("branch_cnt_1", DW'(branch_cnt), 32'd1);
        upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("train_nt", 32'h100, 1'b1, 1'b0, 32'h80);
        check("branch_cnt_2", DW'(branch_cnt), 32'd2);
        check("mispredict_cnt_0", DW'(mispredict_cnt), 32'd0);

        // Idle cycle holds state
        @(posedge clk);
        #1;
        look("hold", 32'h100, 1'b1, 1'b0, 32'h80);
        check("hold_branch_cnt", DW'(branch_cnt), 32'd2);

        // Saturation at 11 and 00
        for (int i = 0; i < 4; i++) upd(32'h200, 1'b1, 32'h2A0, 1'b0);
        look("sat_11", 32'h200, 1'b1, 1'b1, 32'h2A0);
        upd(32'h200, 1'b0, 32'hDEAD0, 1'b0);
        look("sat_10", 32'h200, 1'b1, 1'b1, 32'h2A0);
        upd(32'h200, 1'b0, 32'hDEAD0, 1'b0);
        look("sat_01", 32'h200, 1'b1, 1'b0, 32'h2A0);
        upd(32'h200, 1'b0, 32'hDEAD0, 1'b0);
        upd(32'h200, 1'b0, 32'hDEAD0, 1'b0);
        look("sat_00", 32'h200, 1'b1, 1'b0, 32'h2A0);
        upd(32'h200, 1'b1, 32'h2B0, 1'b0);
        look("from00_to01", 32'h200, 1'b1, 1'b0, 32'h2B0);
        upd(32'h200, 1'b1, 32'h2C0, 1'b0);
        look("from01_to10", 32'h200, 1'b1, 1'b1, 32'h2C0);

        // Aliasing on index 0
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        look("alias_train", 32'h100, 1'b1, 1'b1, 32'h80);
        upd(32'h140, 1'b0, 32'h44, 1'b0);
        look("alias_evicted", 32'h100, 1'b0, 1'b0, 32'h0);
        look("alias_new", 32'h140, 1'b1, 1'b0, 32'h44);
        upd(32'h140, 1'b1, 32'h48, 1'b0);
        look("alias_new_01to10", 32'h140, 1'b1, 1'b1, 32'h48);

        // Same-cycle lookup/update: pre-update contents, visible next cycle
        if_pc          = 32'h300;
        upd_valid      = 1'b1;
        upd_pc         = 32'h300;
        upd_taken      = 1'b1;
        upd_target     = 32'h3C0;
        upd_mispredict = 1'b0;
        #1;
        check("same_cycle_hit", {31'd0, pred_hit}, 32'd0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        look("next_cycle", 32'h300, 1'b1, 1'b1, 32'h3C0);

        // Reset priority over update, and all trained state discarded
        rst        = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h304;
        upd_taken  = 1'b1;
        upd_target = 32'h500;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        upd_valid = 1'b0;
        look("rst_prio_dropped", 32'h304, 1'b0, 1'b0, 32'h0);
        look("rst_discard", 32'h300, 1'b0, 1'b0, 32'h0);
        check("rst_prio_branch_cnt", DW'(branch_cnt), 32'd0);
        check("rst_prio_mispredict_cnt", DW'(mispredict_cnt), 32'd0);

        // Mispredict without upd_valid is ignored
        upd_mispredict = 1'b1;
        @(posedge clk);
        #1;
        upd_mispredict = 1'b0;
        check("misp_unqualified", DW'(mispredict_cnt), 32'd0);

        // Statistics saturation at 15
        for (int i = 0; i < 5; i++) upd(32'h10, 1'b1, 32'h20, 1'b1);
        check("stats5_branch", DW'(branch_cnt), 32'd5);
        check("stats5_misp", DW'(mispredict_cnt), 32'd5);
        upd(32'h10, 1'b1, 32'h20, 1'b0);
        check("stats6_branch", DW'(branch_cnt), 32'd6);
        check("stats6_misp", DW'(mispredict_cnt), 32'd5);
        for (int i = 0; i < 20; i++) upd(32'h10, 1'b0, 32'h20, 1'b1);
        check("stats_sat_branch", DW'(branch_cnt), 32'd15);
        check("stats_sat_misp", DW'(mispredict_cnt), 32'd15);
        look("stats_entry", 32'h10, 1'b1, 1'b0, 32'h20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
